// File: rtl/level_pkg.sv
// ============================================================================
// level_pkg : shared types and constants for the level sequencer slice
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package level_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ARM  = 1'b1
  } state_t;

  localparam int                  LEVEL_W           = 3;
  localparam logic [LEVEL_W-1:0]  MAX_LEVEL         = 3'd7;
  localparam int                  DEF_BLINK_HALF    = 25_000_000;
  localparam int                  DEF_ARM_TOGGLES   = 6;

endpackage

`default_nettype wire

// File: rtl/level_sequencer_btn_edge.sv
// ============================================================================
// btn_edge : two-flop synchronizer followed by a rising-edge pulse generator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync_a;
  logic sync_b;
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_a    <= btn;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
    end
  end

  // Decoded from flops only, so a button never reaches an output combinationally.
  assign pulse = sync_b & ~sync_prev;

endmodule

`default_nettype wire

// File: rtl/level_sequencer.sv
// ============================================================================
// level_sequencer : add/remove buttons to a 3-bit level with a blinking
//                   confirmation window before each increment commits
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_sequencer
  import level_pkg::*;
#(
  parameter int BLINK_HALF  = DEF_BLINK_HALF,
  parameter int ARM_TOGGLES = DEF_ARM_TOGGLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_inc,
  input  logic               btn_dec,
  output logic [LEVEL_W-1:0] count,
  output logic               blink,
  output logic               full,
  output logic               busy
);

  localparam int                 TIMER_W    = $clog2(BLINK_HALF);
  localparam int                 TOG_W      = $clog2(ARM_TOGGLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BLINK_HALF - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(ARM_TOGGLES - 1);

  logic inc_req;
  logic dec_req;

  btn_edge u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .pulse (inc_req)
  );

  btn_edge u_dec_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_dec),
    .pulse (dec_req)
  );

  state_t             state,   state_n;
  logic [TIMER_W-1:0] timer,   timer_n;
  logic [TOG_W-1:0]   toggles, toggles_n;
  logic [LEVEL_W-1:0] count_n;
  logic               blink_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      toggles <= '0;
      count   <= '0;
      blink   <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      toggles <= toggles_n;
      count   <= count_n;
      blink   <= blink_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    toggles_n = toggles;
    count_n   = count;
    blink_n   = blink;
    case (state)
      IDLE: begin
        if (inc_req && !dec_req && count != MAX_LEVEL) begin
          state_n   = ARM;
          blink_n   = 1'b1;
          timer_n   = '0;
          toggles_n = '0;
        end else if (dec_req && !inc_req && count != '0) begin
          count_n = count - LEVEL_W'(1);
        end
      end
      ARM: begin
        // A remove anywhere in the window, including the commit cycle, cancels.
        if (dec_req) begin
          state_n   = IDLE;
          blink_n   = 1'b0;
          timer_n   = '0;
          toggles_n = '0;
        end else if (timer == TIMER_LAST) begin
          timer_n = '0;
          if (toggles == TOG_LAST) begin
            state_n   = IDLE;
            blink_n   = 1'b0;
            toggles_n = '0;
            count_n   = count + LEVEL_W'(1);
          end else begin
            blink_n   = ~blink;
            toggles_n = toggles + TOG_W'(1);
          end
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        blink_n = 1'b0;
      end
    endcase
  end

  assign full = (count == MAX_LEVEL);
  assign busy = (state == ARM);

endmodule

`default_nettype wire

// File: doc/level_sequencer.md
# level_sequencer

Upstream stage for `decoder_rows`: it turns two push-button inputs into the 3-bit level `count` and the `blink` flag that drive the 7-row bar display. An "add" request does not commit immediately. It arms a confirmation window in which `blink` flashes the next row. The level increments only when the window completes, and a "remove" during the window cancels it. Outside a window, a "remove" decrements the level immediately.

## Interface
- `BLINK_HALF`, 25_000_000: clock cycles per blink half-period (≥2).
- `ARM_TOGGLES`, 6: number of half-periods in a confirmation window (≥2).

- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_inc`  in  1  raw asynchronous add button, active-high.
- `btn_dec`  in  1  raw asynchronous remove button, active-high.
- `count`  out  3  committed level, 0..7, feeds `decoder_rows.count`.
- `blink`  out  1  next-row flash, feeds `decoder_rows.blink`.
- `full`  out  1  high when `count == 7`.
- `busy`  out  1  high while in ARM.

## Operation
- **Reset values:**
  - `count` = 0, `blink` = 0, `full` = 0, `busy` = 0.
  - state = IDLE; timer and toggle counter = 0.
  - All synchronizer and edge flops = 0.
- **Input conditioning:**
  - Each button passes through a 2-flop synchronizer and then a rising-edge detector.
  - This yields one-cycle pulses `inc_req` and `dec_req`.
  - A button held through reset release produces one request.
  - A held button produces no repeats.
- **States:** IDLE and ARM.
- **IDLE:**
  - `inc_req` alone with `count < 7`: go to ARM, set `blink` = 1, timer = 0, toggles = 0.
  - `inc_req` alone with `count == 7`: ignored.
  - `dec_req` alone with `count > 0`: `count` decrements by 1, stay in IDLE.
  - `dec_req` alone with `count == 0`: ignored.
  - `inc_req` and `dec_req` in the same cycle: both ignored.
- **ARM:**
  - The timer increments every cycle.
  - When timer == `BLINK_HALF`−1, a terminal event occurs and the timer returns to 0.
  - On terminal events 1..`ARM_TOGGLES`−1: `blink` toggles and toggles increments.
  - On terminal event `ARM_TOGGLES`: `count` increments by 1, `blink` = 0, go to IDLE.
  - `dec_req` in any ARM cycle cancels: `blink` = 0, go to IDLE, `count` unchanged, timer and toggles cleared.
  - `dec_req` coinciding with the committing terminal event: cancel wins.
  - `inc_req` in ARM is ignored.
- **Derived outputs:**
  - `full` and `busy` are combinational from registered state and `count`.
  - `blink` is always 0 in IDLE.
- **Arithmetic:**
  - The timer width is clog2(`BLINK_HALF`) and the toggle-counter width is clog2(`ARM_TOGGLES`+1).
  - `count` never wraps. Commit is only reachable with `count ≤ 6`.

## Timing
- Button pin rise to request consumption is 3 clock edges: edges 1 and 2 are the synchronizer, edge 3 acts on the request.
- `blink`, `count` and `busy` change on the edge that consumes the request.
- An ARM window lasts exactly `ARM_TOGGLES`×`BLINK_HALF` cycles from entry to commit.
- Mid-operation reset:
  - Any cycle with `reset` high forces all reset values on that edge.
  - A pending ARM is discarded with no commit.
- Outputs are registered or decoded from registers. There is no combinational path from a button to any output.

## Structure
- **Package `level_pkg`:**
  - State enum {IDLE, ARM}.
  - `LEVEL_W` = 3 and `MAX_LEVEL` = 7.
  - Default parameter constants.
- **Sub-module `btn_edge`:** 2-flop synchronizer plus rising-edge pulse, with synchronous active-high reset. It is instantiated twice.
- **Top:** FSM, timer, toggle counter and level register.

## Test plan
Benches use `BLINK_HALF` = 4 and `ARM_TOGGLES` = 4.

- **Reset:** assert `reset` for 2 cycles → all outputs 0; no request pulses after release with buttons low.
- **Single add:**
  - Stimulus: `btn_inc` rises with `count` = 0.
  - `busy` goes to 1 at the 3rd edge.
  - `blink` pattern is 1,1,1,1,0,0,0,0,1,1,1,1, then 0 with `count` = 1 and `busy` = 0 at cycle 16 after entry.
- **Saturation:** 7 adds → `count` = 7, `full` = 1; an 8th `btn_inc` → `busy` stays 0, `count` stays 7.
- **Cancel:**
  - Stimulus: with `count` = 2, add, then `btn_dec` consumed at cycle 6 of ARM.
  - Required: `blink` = 0 and `busy` = 0 next edge; `count` stays 2.
  - Also: a dec landing exactly on the commit edge → `count` stays 2.
- **Decrement and ignores:**
  - `count` 3 plus `btn_dec` in IDLE → 2.
  - `btn_dec` at `count` 0 → stays 0.
  - Simultaneous `inc_req` and `dec_req` in IDLE → no change.
  - A held `btn_inc` → exactly one ARM.
- **Reset mid-ARM:** `reset` during ARM cycle 10 → `count` returns to 0, `blink` = 0, no later commit.
